// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: encode/decode rules and all-ones limit, used by the
// counter RTL and by bench models. Values are carried zero-extended in 32 bits.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  // Gray encode: each bit is the XOR of itself and the next-higher binary bit.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray decode, matching the gray_binary decoder: prefix XOR from the MSB down.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = '0;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // All-ones value of a w-bit count (the terminal value when counting up).
  function automatic logic [MAX_WIDTH-1:0] max_of(input int unsigned w);
    logic [MAX_WIDTH-1:0] m;
    if (w >= MAX_WIDTH) begin
      m = {MAX_WIDTH{1'b1}};
    end else begin
      m = (32'd1 << w) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_counter_encoder_bin2gray_enc.sv
// Pure combinational WIDTH-bit binary-to-Gray encoder built on the shared
// gray_pkg encode rule.
module bin2gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [MAX_WIDTH-1:0] wide_gray_s;

  assign wide_gray_s = bin2gray(MAX_WIDTH'(bin));
  assign gray        = wide_gray_s[WIDTH-1:0];

endmodule

// File: rtl/gray_counter_encoder.sv
// Registered binary counter with registered Gray-code, terminal-count and wrap outputs.
// Define GRAY_UPDOWN_EN to add the dir port and down counting; otherwise up-only.
module gray_counter_encoder
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned INIT_BIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
`ifdef GRAY_UPDOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_BIN   = WIDTH'(max_of(WIDTH));
  localparam logic [WIDTH-1:0] INIT_C    = WIDTH'(INIT_BIN);
  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(INIT_BIN)));

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("gray_counter_encoder: WIDTH must be in 2..32");
    end
  endgenerate

  logic [WIDTH-1:0] bin_r;
  logic [WIDTH-1:0] gray_r;
  logic             tc_r;
  logic             wrap_r;

  logic [WIDTH-1:0] next_bin_s;
  logic [WIDTH-1:0] next_gray_s;
  logic             next_wrap_s;
  logic             next_tc_s;
  logic             update_s;
  logic             up_s;

`ifdef GRAY_UPDOWN_EN
  assign up_s = dir;
`else
  assign up_s = 1'b1;
`endif

  // Next-state selection with priority clr > load > en > hold.
  always_comb begin
    next_bin_s  = bin_r;
    next_wrap_s = 1'b0;
    update_s    = 1'b0;
    if (clr) begin
      next_bin_s = INIT_C;
      update_s   = 1'b1;
    end else if (load) begin
      next_bin_s = load_bin;
      update_s   = 1'b1;
    end else if (en) begin
      update_s = 1'b1;
      if (up_s) begin
        next_bin_s  = bin_r + ONE_C;
        next_wrap_s = (bin_r == MAX_BIN);
      end else begin
        next_bin_s  = bin_r - ONE_C;
        next_wrap_s = (bin_r == ZERO_C);
      end
    end else begin
      next_bin_s  = bin_r;
      next_wrap_s = 1'b0;
    end
  end

  // Terminal count follows next-bin and direction in effect; held while idle.
  always_comb begin
    next_tc_s = tc_r;
    if (update_s) begin
      if (up_s) begin
        next_tc_s = (next_bin_s == MAX_BIN);
      end else begin
        next_tc_s = (next_bin_s == ZERO_C);
      end
    end else begin
      next_tc_s = tc_r;
    end
  end

  bin2gray_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin  (next_bin_s),
    .gray (next_gray_s)
  );

  // Output register: bin and its Gray code always update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= INIT_C;
      gray_r <= INIT_GRAY;
      tc_r   <= (INIT_C == MAX_BIN);
      wrap_r <= 1'b0;
    end else begin
      bin_r  <= next_bin_s;
      gray_r <= next_gray_s;
      tc_r   <= next_tc_s;
      wrap_r <= next_wrap_s;
    end
  end

  assign bin  = bin_r;
  assign gray = gray_r;
  assign tc   = tc_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_gray_counter_encoder.sv
// Directed and randomized bench for gray_counter_encoder (WIDTH=4, INIT_BIN=0)
// against an arithmetic reference model; honours GRAY_UPDOWN_EN.
module tb_gray_counter_encoder;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_bin = 4'd0;
  logic       dir = 1'b1;
  logic [3:0] bin;
  logic [3:0] gray;
  logic       tc;
  logic       wrap;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int m_bin  = 0;
  int m_tc   = 0;
  int m_wrap = 0;

  gray_counter_encoder #(.WIDTH(4), .INIT_BIN(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_bin (load_bin),
`ifdef GRAY_UPDOWN_EN
    .dir      (dir),
`endif
    .bin      (bin),
    .gray     (gray),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int eg;
    eg = m_bin ^ (m_bin / 2);
    check({tag, ".bin"},  32'(bin),  32'(m_bin));
    check({tag, ".gray"}, 32'(gray), 32'(eg));
    check({tag, ".tc"},   32'(tc),   32'(m_tc));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, ".dec"},  gray2bin(32'(gray)), 32'(m_bin));
  endtask

  task automatic model_reset();
    m_bin = 0; m_tc = 0; m_wrap = 0;
  endtask

  // Drive one cycle of controls, update the model, check outputs after the edge.
  task automatic cycle(input logic e, input logic c, input logic l, input logic [3:0] lb,
                       input logic d, input string tag);
    logic [3:0] prev_gray;
    bit         up;
    bit         pure_step;
    en = e; clr = c; load = l; load_bin = lb; dir = d;
`ifdef GRAY_UPDOWN_EN
    up = d;
`else
    up = 1'b1;
`endif
    prev_gray = gray;
    pure_step = e && !c && !l;
    @(posedge clk);
    #1;
    if (c) begin
      m_bin = 0; m_wrap = 0; m_tc = up ? 0 : 1;
    end else if (l) begin
      m_bin = int'(lb); m_wrap = 0; m_tc = up ? int'(m_bin == 15) : int'(m_bin == 0);
    end else if (e) begin
      if (up) begin
        m_wrap = int'(m_bin == 15); m_bin = (m_bin + 1) % 16; m_tc = int'(m_bin == 15);
      end else begin
        m_wrap = int'(m_bin == 0);  m_bin = (m_bin + 15) % 16; m_tc = int'(m_bin == 0);
      end
    end else begin
      m_wrap = 0;
    end
    check_all(tag);
    if (pure_step) check({tag, ".onebit"}, 32'($countones(gray ^ prev_gray)), 32'd1);
  endtask

  initial begin
    // 1. Reset with en high, release, count to 5, then asynchronous reset.
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    #1;
    check_all("rst_release");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "cnt5");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Full up sequence with one-bit steps and wrap back to zero.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "seq16");
    check("seq16.end_wrap", 32'(wrap), 32'd1);

    // 3. Terminal count at 15, wrap pulse lasting exactly one cycle.
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "to15");
    check("tc_at_15", 32'(tc), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, "wrap_step");
    check("wrap_pulse", 32'(wrap), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, "wrap_gone");
    check("wrap_one_cycle", 32'(wrap), 32'd0);

    // 4. Load beats en; clr beats load.
    cycle(1'b1, 1'b0, 1'b1, 4'b1010, 1'b1, "load");
    check("load_gray", 32'(gray), 32'hF);
    cycle(1'b0, 1'b1, 1'b1, 4'b0111, 1'b1, "clr_over_load");
    check("clr_bin", 32'(bin), 32'd0);

`ifdef GRAY_UPDOWN_EN
    // 5. Down count from zero wraps to fifteen.
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "down_wrap");
    check("down_gray15", 32'(gray), 32'h8);
    check("down_wrap_flag", 32'(wrap), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "down14");
    check("down_gray14", 32'(gray), 32'h9);
`endif

    // 6. Randomized en with rare load/clr (and random dir when present).
    for (int i = 0; i < 200; i++) begin
      logic e, c, l, d;
      logic [3:0] lb;
      e  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 31) == 0);
      l  = ($urandom_range(0, 15) == 0);
      lb = 4'($urandom_range(0, 15));
      d  = 1'($urandom_range(0, 1));
      cycle(e, c, l, lb, d, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
